fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output reorder buffer for the radix-2² SDF FFT pipeline. Sits after the last butterfly stage and accepts one complex sample per valid cycle in bit-reversed frequency order. Emits each N-point frame in natural order as a continuous N-cycle burst. Uses a ping-pong pair of N-word banks, so a new frame can be written while the previous frame is read out.

## Interface
Parameters:
- WIDTH, 16, bit width of each real/imaginary component (two's complement, passed through unmodified)
- N, 64, FFT frame length; must be a power of two, at least 4
- LOG2N, 6, log2(N); must match N

Ports:
- i_clk  input  1  single clock, rising edge
- i_rstn  input  1  reset, asynchronous, active-low
- i_valid  input  1  input sample strobe
- i_sof  input  1  start of frame; qualified by i_valid, marks bit-reversed index 0
- i_rX  input  WIDTH  input real part
- i_iX  input  WIDTH  input imaginary part
- o_valid  output  1  output sample strobe
- o_sof  output  1  high with natural index 0 of each output frame
- o_rZ  output  WIDTH  output real part
- o_iZ  output  WIDTH  output imaginary part
- o_err  output  1  one-cycle pulse on a frame-sync error (present only with REORDER_ERR_EN)

## Operation
Write side:
- LOG2N-bit write counter wcnt and a write-bank select wbank.
- On i_valid=1: store {i_rX, i_iX} in bank wbank at address bitrev(k).
- k = 0 if i_sof=1, otherwise k = wcnt. Then wcnt <= k+1 (mod N).
- When k = N-1 is written: set full[wbank], toggle wbank, and wcnt wraps to 0.
- i_sof with wcnt≠0 is a resync. The partial frame is discarded, the current sample becomes index 0 in the same bank, and full is not set. This raises o_err if enabled.
- i_sof is not required every frame. Back-to-back frames without i_sof are continuous.
- i_valid=0 holds all write state. Gaps of any length are allowed.

Read side, FSM with states IDLE and READ:
- IDLE: if full[rbank]=1, go to READ with rcnt=0.
- READ: each cycle, read address rcnt from bank rbank, then rcnt++.
- After the read of rcnt=N-1: clear full[rbank] and toggle rbank.
  - If full of the other bank is already set, stay in READ with rcnt=0, giving back-to-back frames with no gap.
  - Otherwise return to IDLE.
- Read data is registered: o_valid, o_sof, o_rZ and o_iZ lag the read address by one cycle.
- o_sof=1 exactly when the presented sample is natural index 0.

Collisions:
- The bank being read is never written.
- Because the input rate is at most one sample per cycle, a bank cannot refill before its readout ends. No overflow handling is required.
- If full[wbank] is still set when a write arrives (impossible under legal input), the write proceeds. No protection is provided.

Reset:
- Asynchronous. Clears wcnt, rcnt, wbank, rbank, both full flags and the FSM (IDLE).
- Outputs reset to o_valid=0, o_sof=0, o_rZ=0, o_iZ=0, o_err=0.
- Bank RAM contents are not cleared.
- Reset mid-frame abandons both banks. The first frame after reset needs either N samples or i_sof.

## Timing
- Let edge t capture the input sample with k=N-1.
  - full is set at edge t.
  - The FSM enters READ at edge t+1 and issues address 0.
  - The first output (o_valid=1, o_sof=1) is visible after edge t+2.
- Latency: 2 cycles from the last input edge to the first output.
- Output burst: exactly N consecutive o_valid=1 cycles per frame, never gapped.
- Continuous input at 1 sample/cycle gives continuous output at 1 sample/cycle after the initial N+2 cycle fill.
- o_err pulses for one cycle after the edge that captured the offending i_sof.
- o_rZ and o_iZ hold their last value when o_valid=0.

## Configuration
- REORDER_ERR_EN defined: the o_err port and the resync detector are present.
- REORDER_ERR_EN undefined: the o_err port and its logic are removed. Resync behaviour (discard and restart at index 0) is unchanged.

## Test plan
- Natural readout: N=64, 64 continuous inputs with i_rX=k, i_iX=-k, i_sof at k=0.
  - Outputs j=0..63 are i_rX=bitrev6(j), e.g. j=1→32, j=3→48, j=63→63.
  - o_sof only at j=0. First o_valid 2 cycles after the last input.
- Back-to-back: 3 frames at full rate with values frame*100+k.
  - 192 contiguous o_valid cycles with correct per-frame data and o_sof every 64th cycle.
- Gapped input: i_valid toggling 1/0 for one frame.
  - Same 64-cycle contiguous burst starting 2 cycles after the last valid input.
- Resync: i_sof at k=20 of a frame, then 64 samples.
  - o_err pulses once. Only the post-resync frame is output. No output from the partial frame.
- Reset: assert i_rstn=0 during output burst j=30.
  - o_valid=0 and o_rZ=o_iZ=0 immediately, with no clock edge needed.
  - After release, no output until a full new frame is written.
- Build without REORDER_ERR_EN: repeat the resync test.
  - Identical data output, and the o_err port is absent.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong output reorder buffer for the radix-2^2 SDF FFT.
// Samples arrive in bit-reversed order and leave as an N-cycle natural-order burst.
// Optional macro REORDER_ERR_EN adds the o_err port and the resync detector.
module fft_bitrev_reorder #(
  parameter int WIDTH = 16,
  parameter int N     = 64,
  parameter int LOG2N = 6
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [WIDTH-1:0] i_rX,
  input  logic [WIDTH-1:0] i_iX,
  output logic             o_valid,
  output logic             o_sof,
  output logic [WIDTH-1:0] o_rZ,
  output logic [WIDTH-1:0] o_iZ
`ifdef REORDER_ERR_EN
  ,
  output logic             o_err
`endif
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
    return r;
  endfunction

  // Both banks live in one array; the MSB of the address selects the bank.
  logic [2*WIDTH-1:0] mem [2*N];

  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] wk;
  logic             wbank;
  logic             wrLast;
  logic [1:0]       full;

  state_t           state, nextState;
  logic [LOG2N-1:0] rcnt, nextRcnt;
  logic             rbank, nextRbank;
  logic             rdLast;

  // Effective write index: i_sof forces index 0 and restarts the frame.
  always_comb begin
    wk     = i_sof ? '0 : wcnt;
    wrLast = i_valid && (wk == LAST);
  end

  // Write counter and write-bank select.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (i_valid) begin
      if (wk == LAST) begin
        wcnt  <= '0;
        wbank <= ~wbank;
      end else begin
        wcnt  <= wk + 1'b1;
      end
    end
  end

  // Sample storage at the bit-reversed address; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (i_valid) mem[{wbank, bitrev(wk)}] <= {i_rX, i_iX};
  end

  // Bank-full flags: set by the writer on the last sample, cleared by the reader.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      full <= '0;
    end else begin
      if (rdLast) full[rbank] <= 1'b0;
      if (wrLast) full[wbank] <= 1'b1;
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      state <= nextState;
      rcnt  <= nextRcnt;
      rbank <= nextRbank;
    end
  end

  // Read FSM next state: stay in READ across banks when the other bank is ready.
  always_comb begin
    nextState = state;
    nextRcnt  = rcnt;
    nextRbank = rbank;
    rdLast    = 1'b0;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          nextState = READ;
          nextRcnt  = '0;
        end
      end
      READ: begin
        nextRcnt = rcnt + 1'b1;
        if (rcnt == LAST) begin
          rdLast    = 1'b1;
          nextRbank = ~rbank;
          nextRcnt  = '0;
          if (!full[~rbank]) nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Registered read data; data outputs hold while not reading.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_rZ    <= '0;
      o_iZ    <= '0;
    end else begin
      o_valid <= (state == READ);
      o_sof   <= (state == READ) && (rcnt == '0);
      if (state == READ) {o_rZ, o_iZ} <= mem[{rbank, rcnt}];
    end
  end

`ifdef REORDER_ERR_EN
  // One-cycle pulse when i_sof arrives in the middle of a frame.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) o_err <= 1'b0;
    else         o_err <= i_valid && i_sof && (wcnt != '0);
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int W = 16;
  localparam int NN = 64;

  logic         i_clk, i_rstn, i_valid, i_sof;
  logic [W-1:0] i_rX, i_iX;
  logic         o_valid, o_sof;
  logic [W-1:0] o_rZ, o_iZ;
`ifdef REORDER_ERR_EN
  logic         o_err;
`endif

  fft_bitrev_reorder #(.WIDTH(W), .N(NN), .LOG2N(6)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_valid(i_valid),
    .i_sof  (i_sof),
    .i_rX   (i_rX),
    .i_iX   (i_iX),
    .o_valid(o_valid),
    .o_sof  (o_sof),
    .o_rZ   (o_rZ),
    .o_iZ   (o_iZ)
`ifdef REORDER_ERR_EN
    ,
    .o_err  (o_err)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Output log, sampled on the falling edge.
  logic [W-1:0] qRe[$];
  logic [W-1:0] qIm[$];
  logic         qSof[$];
  int           qCyc[$];
  int           errCnt = 0;

  always @(negedge i_clk) begin
    if (o_valid) begin
      qRe.push_back(o_rZ);
      qIm.push_back(o_iZ);
      qSof.push_back(o_sof);
      qCyc.push_back(cyc);
    end
`ifdef REORDER_ERR_EN
    if (o_err) errCnt = errCnt + 1;
`endif
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int br6(input int x);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (x[b]) r = r | (1 << (5 - b));
    return r;
  endfunction

  task automatic clearLog();
    qRe.delete(); qIm.delete(); qSof.delete(); qCyc.delete();
  endtask

  task automatic drive(input logic s, input logic [W-1:0] r);
    i_valid = 1'b1; i_sof = s; i_rX = r; i_iX = -r;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0; i_sof = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Frame f of the burst carries base + f*step + k at input index k.
  task automatic checkBurst(input string nm, input int nFrames, input int base,
                            input int step, input int firstCyc);
    logic [W-1:0] er, ei;
    chk($sformatf("%s count", nm), qRe.size(), nFrames * NN);
    for (int j = 0; j < qRe.size() && j < nFrames * NN; j++) begin
      er = W'(base + (j / NN) * step + br6(j % NN));
      ei = -er;
      chk($sformatf("%s re[%0d]", nm, j), qRe[j], er);
      chk($sformatf("%s im[%0d]", nm, j), qIm[j], ei);
      chk($sformatf("%s sof[%0d]", nm, j), qSof[j], (j % NN) == 0);
      chk($sformatf("%s cyc[%0d]", nm, j), qCyc[j], firstCyc + j);
    end
  endtask

  typedef struct {
    int           j;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sof;
  } vec_t;

  vec_t tbl[7];
  int   lastEdge;

  initial begin
    tbl[0] = '{0,  16'd0,  16'h0000, 1'b1};
    tbl[1] = '{1,  16'd32, 16'hFFE0, 1'b0};
    tbl[2] = '{2,  16'd16, 16'hFFF0, 1'b0};
    tbl[3] = '{3,  16'd48, 16'hFFD0, 1'b0};
    tbl[4] = '{5,  16'd40, 16'hFFD8, 1'b0};
    tbl[5] = '{6,  16'd24, 16'hFFE8, 1'b0};
    tbl[6] = '{63, 16'd63, 16'hFFC1, 1'b0};

    i_rstn = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_rX = '0; i_iX = '0;
    #2;
    chk("reset o_valid", o_valid, 0);
    chk("reset o_sof", o_sof, 0);
    chk("reset o_rZ", o_rZ, 0);
    chk("reset o_iZ", o_iZ, 0);
    #20 i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // Natural readout of one frame.
    clearLog();
    for (int k = 0; k < NN; k++) drive(k == 0, W'(k));
    lastEdge = cyc;
    idle(80);
    chk("t1 count", qRe.size(), NN);
    if (qRe.size() == NN) begin
      foreach (tbl[i]) begin
        chk($sformatf("t1 tbl re j=%0d", tbl[i].j), qRe[tbl[i].j], tbl[i].re);
        chk($sformatf("t1 tbl im j=%0d", tbl[i].j), qIm[tbl[i].j], tbl[i].im);
        chk($sformatf("t1 tbl sof j=%0d", tbl[i].j), qSof[tbl[i].j], tbl[i].sof);
      end
    end
    checkBurst("t1", 1, 0, 0, lastEdge + 2);
    chk("t1 no err", errCnt, 0);

    // Three back-to-back frames; i_sof only on the first.
    clearLog();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < NN; k++) begin
        drive(f == 0 && k == 0, W'(f * 100 + k));
        if (f == 0 && k == NN - 1) lastEdge = cyc;
      end
    idle(80);
    checkBurst("t2", 3, 0, 100, lastEdge + 2);

    // Gapped input, valid every other cycle.
    clearLog();
    for (int k = 0; k < NN; k++) begin
      drive(k == 0, W'(500 + k));
      if (k < NN - 1) idle(1);
    end
    lastEdge = cyc;
    idle(80);
    checkBurst("t3", 1, 500, 0, lastEdge + 2);

    // Resync at k=20: partial frame discarded.
    clearLog();
    errCnt = 0;
    for (int k = 0; k < 20; k++) drive(k == 0, W'(900 + k));
    for (int k = 0; k < NN; k++) drive(k == 0, W'(1000 + k));
    lastEdge = cyc;
    idle(80);
    checkBurst("t4", 1, 1000, 0, lastEdge + 2);
`ifdef REORDER_ERR_EN
    chk("t4 err pulses", errCnt, 1);
`endif

    // Reset during output j=30, asserted between clock edges.
    clearLog();
    for (int k = 0; k < NN; k++) drive(k == 0, W'(2000 + k));
    repeat (32) @(posedge i_clk);
    #3;
    chk("t5 valid before reset", o_valid, 1);
    chk("t5 re before reset", o_rZ, 2000 + br6(30));
    i_rstn = 1'b0;
    #1;
    chk("t5 reset o_valid", o_valid, 0);
    chk("t5 reset o_sof", o_sof, 0);
    chk("t5 reset o_rZ", o_rZ, 0);
    chk("t5 reset o_iZ", o_iZ, 0);
    #10 i_rstn = 1'b1;
    clearLog();
    idle(80);
    chk("t5 quiet after reset", qRe.size(), 0);
    for (int k = 0; k < NN - 1; k++) drive(1'b0, W'(3000 + k));
    idle(10);
    chk("t5 quiet partial frame", qRe.size(), 0);
    drive(1'b0, W'(3000 + NN - 1));
    lastEdge = cyc;
    idle(80);
    checkBurst("t5", 1, 3000, 0, lastEdge + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
